// File: rtl/multiword_add_sequencer_pkg.sv
// rtl/multiword_add_sequencer_pkg.sv - shared FSM encoding and index-width helper
// Contents:
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   idx_width : width of the word index counter, never below one bit
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports:
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiword_add_sequencer_carry_in_adder.sv
// rtl/multiword_add_sequencer_carry_in_adder.sv - N-bit ripple adder with carry in
// Ports:
//   x, y : N-bit addends
//   ci   : carry in
//   sum  : N-bit sum
//   co   : carry out of the top bit
module carry_in_adder #(
    parameter int N = 6
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign co = c[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - word-serial multi-precision add/subtract engine
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake
//   a, b, sub            : W-bit operands, 0 = A+B, 1 = A-B
//   out_valid, out_ready : result handshake
//   result, carry_out    : W-bit result, final carry (for sub: 1 = no borrow)
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int N     = 6,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] result,
    output logic               carry_out
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;

    logic [N-1:0]    slice_x, slice_y, slice_sum;
    logic            slice_co;
    logic            last_word;

    // Word mux: B is inverted for subtraction; the +1 comes from carry_q,
    // which is seeded with sub at acceptance.
    assign slice_x   = a_q[int'(idx_q)*N +: N];
    assign slice_y   = b_q[int'(idx_q)*N +: N] ^ {N{sub_q}};
    assign last_word = (idx_q == IW'(WORDS - 1));

    carry_in_adder #(.N(N)) u_adder (
        .x   (slice_x),
        .y   (slice_y),
        .ci  (carry_q),
        .sum (slice_sum),
        .co  (slice_co)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    idx_d    = '0;
                    carry_d  = sub;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*N +: N] = slice_sum;
                carry_d = slice_co;
                if (last_word) begin
                    cout_d  = slice_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - self-checking bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

    localparam int N     = 6;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, sub, out_valid, out_ready, carry_out;
    logic [W-1:0] a, b, result;

    logic         in_valid1, in_ready1, sub1, out_valid1, out_ready1, carry_out1;
    logic [N-1:0] a1, b1, result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    multiword_add_sequencer #(.N(N), .WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .result    (result1),
        .carry_out (carry_out1)
    );

    // Reference: plain W-bit arithmetic; for subtraction carry means a >= b.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        logic [W:0] t;
        if (s) begin
            t[W-1:0] = x - y;
            t[W]     = (x >= y);
        end else begin
            t = {1'b0, x} + {1'b0, y};
        end
        return t;
    endfunction

    // Drives one full transaction on the 4-word instance; returns observations.
    task automatic do_txn(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s,
                          output logic [W-1:0] res, output logic co, output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = xa; b = xb; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 20) lat = 99;
        res = result; co = carry_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 0; out_ready = 0; sub = 0; a = '0; b = '0;
        in_valid1 = 0; out_ready1 = 0; sub1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b result=%h carry=%b, want 0/0/0",
                     out_valid, result, carry_out);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] xa [5] = '{24'hFFFFFF, 24'h123456, 24'h000FC0, 24'h000005, 24'h100000};
        logic [W-1:0] xb [5] = '{24'h000001, 24'h654321, 24'h000040, 24'h000007, 24'h000001};
        logic         xs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [5] = '{24'h000000, 24'h777777, 24'h001000, 24'hFFFFFE, 24'h0FFFFF};
        logic         ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] res;
        logic         co;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            do_txn(xa[i], xb[i], xs[i], res, co, lat);
            checks++;
            if (res !== er[i] || co !== ec[i]) begin
                errors++;
                $display("FAIL directed_%0d: result=%h carry=%b, want %h/%b",
                         i, res, co, er[i], ec[i]);
            end
            checks++;
            if (lat !== WORDS) begin
                errors++;
                $display("FAIL latency_%0d: got %0d edges want %0d", i, lat, WORDS);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] res_hold;
        logic         co_hold;
        int           guard = 0;
        a = 24'h0ABCDE; b = 24'h011111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        res_hold = result; co_hold = carry_out;
        checks++;
        if (res_hold !== 24'h0BCDEF || co_hold !== 1'b0) begin
            errors++;
            $display("FAIL bp_result: result=%h carry=%b want 0bcdef/0", res_hold, co_hold);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== res_hold ||
                carry_out !== co_hold) begin
                errors++;
                $display("FAIL bp_hold_%0d: ov=%b ir=%b result=%h carry=%b want 1/0/%h/%b",
                         i, out_valid, in_ready, result, carry_out, res_hold, co_hold);
            end
        end
        a = 24'h000001; b = 24'h000002; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_retire: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (result !== 24'h000003 || carry_out !== 1'b0 || guard !== WORDS) begin
            errors++;
            $display("FAIL bp_next: result=%h carry=%b lat=%0d want 000003/0/%0d",
                     result, carry_out, guard, WORDS);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] res;
        logic         co;
        int           lat;
        a = 24'hFFFFFF; b = 24'h000001; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run: ov=%b result=%h carry=%b ir=%b want 0/0/0/1",
                     out_valid, result, carry_out, in_ready);
        end
        @(posedge clk); #1;
        do_txn(24'h000001, 24'h000001, 1'b0, res, co, lat);
        checks++;
        if (res !== 24'h000002 || co !== 1'b0) begin
            errors++;
            $display("FAIL rst_followup: result=%h carry=%b want 000002/0", res, co);
        end
    endtask

    task automatic test_words1;
        int guard = 0;
        a1 = 6'h3F; b1 = 6'h01; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        while (!out_valid1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (result1 !== 6'h00 || carry_out1 !== 1'b1 || guard !== 1) begin
            errors++;
            $display("FAIL words1: result=%h carry=%b lat=%0d want 00/1/1",
                     result1, carry_out1, guard);
        end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xa, xb, res;
        logic         s, co;
        logic [W:0]   exp;
        int           lat;
        int           bad = 0;
        for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); xb = W'($urandom); s = 1'($urandom_range(0, 1));
            if (i % 10 == 0) xb = xa;
            exp = ref_op(xa, xb, s);
            do_txn(xa, xb, s, res, co, lat);
            checks++;
            if (res !== exp[W-1:0] || co !== exp[W] || lat !== WORDS) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: a=%h b=%h sub=%b got %h/%b lat=%0d want %h/%b lat=%0d",
                             i, xa, xb, s, res, co, lat, exp[W-1:0], exp[W], WORDS);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_words1;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
